// File: rtl/mw_keypad_entry_pkg.sv
// Shared definitions for the microwave keypad front end and its controller.
// Contents: key/BCD widths, default debounce length and the 2-bit FSM state encoding.
package mw_keypad_entry_pkg;

    localparam int unsigned KeyW              = 10;
    localparam int unsigned BcdW              = 4;
    localparam int unsigned DefDebounceCycles = 2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StDebounce = 2'd1,
        StPressed  = 2'd2,
        StWaitRel  = 2'd3
    } state_e;

endpackage

// File: rtl/mw_keypad_entry_onehot10_to_bcd.sv
// Combinational keypad decoder.
// Ports:
//   keys_i  [9:0]  sampled keypad, bit k = digit k pressed
//   bcd_o   [3:0]  index of the highest set bit (meaningful when one_o is high)
//   one_o          exactly one key pressed
//   many_o         more than one key pressed
module mw_keypad_entry_onehot10_to_bcd
    import mw_keypad_entry_pkg::*;
(
    input  logic [KeyW-1:0] keys_i,
    output logic [BcdW-1:0] bcd_o,
    output logic            one_o,
    output logic            many_o
);

    logic [3:0] ones;

    always_comb begin
        bcd_o = '0;
        ones  = '0;
        for (int i = 0; i < KeyW; i++) begin
            if (keys_i[i]) begin
                bcd_o = BcdW'(i);
            end
            ones = ones + 4'(keys_i[i]);
        end
        one_o  = (ones == 4'd1);
        many_o = (ones > 4'd1);
    end

endmodule

// File: rtl/mw_keypad_entry.sv
// Microwave keypad front end: registers the raw keypad, debounces single-key presses,
// emits one key_valid pulse per press with its BCD value, and shifts accepted digits
// into a 4-digit MM:SS register. Multi-key presses are flagged and rejected.
// Ports:
//   clk_i             system clock, rising edge
//   clearn_i          asynchronous active-low reset
//   keypad_i   [9:0]  raw keys, active-high
//   entry_en_i        controller accepts digits
//   digit_clr_i       synchronous clear of the time register (beats a shift)
//   key_bcd_o  [3:0]  BCD value of the last accepted key
//   key_valid_o       one-cycle pulse per debounced press
//   multi_key_o       >1 key seen, held until keypad released
//   min_tens_o .. sec_ones_o  time digits, oldest to newest
module mw_keypad_entry
    import mw_keypad_entry_pkg::*;
#(
    parameter int unsigned DebounceCycles = DefDebounceCycles
) (
    input  logic            clk_i,
    input  logic            clearn_i,
    input  logic [KeyW-1:0] keypad_i,
    input  logic            entry_en_i,
    input  logic            digit_clr_i,
    output logic [BcdW-1:0] key_bcd_o,
    output logic            key_valid_o,
    output logic            multi_key_o,
    output logic [BcdW-1:0] min_tens_o,
    output logic [BcdW-1:0] min_ones_o,
    output logic [BcdW-1:0] sec_tens_o,
    output logic [BcdW-1:0] sec_ones_o
);

    localparam int unsigned     CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);
    localparam logic [KeyW-1:0] KeyOne = KeyW'(1);

    state_e                     state_q, state_d;
    logic [KeyW-1:0]            kb_q;
    logic [CntW-1:0]            cnt_q, cnt_d, cnt_inc;
    logic [BcdW-1:0]            cand_q, cand_d;
    logic [BcdW-1:0]            key_bcd_q, key_bcd_d;
    logic                       multi_q, multi_d;
    logic [3:0][BcdW-1:0]       digits_q, digits_d;

    logic [BcdW-1:0]            kb_bcd;
    logic                       kb_one, kb_many;

    mw_keypad_entry_onehot10_to_bcd u_dec (
        .keys_i (kb_q),
        .bcd_o  (kb_bcd),
        .one_o  (kb_one),
        .many_o (kb_many)
    );

    // State register plus all sequential datapath state.
    always_ff @(posedge clk_i or negedge clearn_i) begin
        if (!clearn_i) begin
            state_q   <= StIdle;
            kb_q      <= '0;
            cnt_q     <= '0;
            cand_q    <= '0;
            key_bcd_q <= '0;
            multi_q   <= 1'b0;
            digits_q  <= '0;
        end else begin
            state_q   <= state_d;
            kb_q      <= keypad_i;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            key_bcd_q <= key_bcd_d;
            multi_q   <= multi_d;
            digits_q  <= digits_d;
        end
    end

    assign cnt_inc = cnt_q + CntW'(1);

    // Next-state logic. The counter tracks stable press samples in StDebounce and
    // consecutive zero samples in StWaitRel.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        multi_d = multi_q;
        unique case (state_q)
            StIdle: begin
                if (kb_one) begin
                    cand_d  = kb_bcd;
                    cnt_d   = CntW'(1);
                    // With a single-sample debounce the first sample already qualifies.
                    state_d = (CntMax == CntW'(1)) ? StPressed : StDebounce;
                end else if (kb_many) begin
                    multi_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StWaitRel;
                end
            end
            StDebounce: begin
                if (kb_q == (KeyOne << cand_q)) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntMax) begin
                        state_d = StPressed;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StPressed: begin
                cnt_d   = '0;
                state_d = StWaitRel;
            end
            StWaitRel: begin
                if (kb_q == '0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntMax) begin
                        cnt_d   = '0;
                        multi_d = 1'b0;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        key_bcd_d = key_bcd_q;
        if (state_d == StPressed && state_q != StPressed) begin
            key_bcd_d = cand_d;
        end

        digits_d = digits_q;
        if (digit_clr_i) begin
            digits_d = '0;
        end else if (state_q == StPressed && entry_en_i) begin
            digits_d = {digits_q[2:0], cand_q};
        end
    end

    // Outputs.
    always_comb begin
        key_valid_o = (state_q == StPressed);
        key_bcd_o   = key_bcd_q;
        multi_key_o = multi_q;
        min_tens_o  = digits_q[3];
        min_ones_o  = digits_q[2];
        sec_tens_o  = digits_q[1];
        sec_ones_o  = digits_q[0];
    end

endmodule

// File: tb/tb_mw_keypad_entry.sv
// Self-checking bench for mw_keypad_entry (D=2): a constant-expectation vector table,
// hand-written corner sequences, and randomized traffic against a press/release model.
module tb_mw_keypad_entry;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       clearn = 1'b1;
    logic [9:0] keypad = '0;
    logic       entry_en = 1'b0;
    logic       digit_clr = 1'b0;
    logic [3:0] key_bcd, min_tens, min_ones, sec_tens, sec_ones;
    logic       key_valid, multi_key;

    always #5 clk = ~clk;

    mw_keypad_entry #(.DebounceCycles(D)) dut (
        .clk_i       (clk),
        .clearn_i    (clearn),
        .keypad_i    (keypad),
        .entry_en_i  (entry_en),
        .digit_clr_i (digit_clr),
        .key_bcd_o   (key_bcd),
        .key_valid_o (key_valid),
        .multi_key_o (multi_key),
        .min_tens_o  (min_tens),
        .min_ones_o  (min_ones),
        .sec_tens_o  (sec_tens),
        .sec_ones_o  (sec_ones)
    );

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // ---------------- reference model ----------------
    // Armed: waiting for a press; a candidate key must be seen alone in D consecutive
    // samples. Locked: a press (or multi-key) was taken; D consecutive empty samples re-arm.
    logic [9:0] m_kb;
    bit         m_armed;
    int         m_run;
    int         m_cand;
    bit         m_pulse;
    int         m_zero;
    bit         m_multi;
    int         m_bcd;
    int         m_dig[4];

    function automatic void model_reset();
        m_kb = '0; m_armed = 1; m_run = 0; m_cand = 0; m_pulse = 0;
        m_zero = 0; m_multi = 0; m_bcd = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
    endfunction

    function automatic logic [15:0] model_digits();
        return {m_dig[3][3:0], m_dig[2][3:0], m_dig[1][3:0], m_dig[0][3:0]};
    endfunction

    function automatic void model_edge();
        logic [9:0] want;
        int n;
        if (digit_clr) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
        end else if (m_pulse && entry_en) begin
            m_dig[3] = m_dig[2]; m_dig[2] = m_dig[1]; m_dig[1] = m_dig[0]; m_dig[0] = m_bcd;
        end
        if (m_pulse) begin
            // the pulse cycle always hands over to release-waiting, sample unused
            m_pulse = 0;
            m_zero = 0;
        end else if (!m_armed) begin
            if (m_kb == 0) begin
                m_zero++;
                if (m_zero >= D) begin
                    m_armed = 1; m_multi = 0; m_zero = 0;
                end
            end else begin
                m_zero = 0;
            end
        end else begin
            n = $countones(m_kb);
            want = 10'(1) << m_cand;
            if (m_run == 0) begin
                if (n == 1) begin
                    for (int k = 0; k < 10; k++) if (m_kb[k]) m_cand = k;
                    m_run = 1;
                end else if (n > 1) begin
                    m_multi = 1; m_armed = 0; m_zero = 0;
                end
            end else if (m_kb == want) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= D) begin
                m_pulse = 1; m_bcd = m_cand; m_armed = 0; m_run = 0;
            end
        end
        m_kb = keypad;
    endfunction

    // One clock: model follows the edge, DUT compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (key_valid) pulse_cnt++;
        check("key_valid", key_valid, m_pulse);
        check("key_bcd", key_bcd, m_bcd);
        check("multi_key", multi_key, m_multi);
        check("digits", dut_digits(), model_digits());
    endtask

    task automatic press(input int key, input int hold, input int rel, input bit en);
        entry_en = en;
        keypad = 10'(1) << key;
        repeat (hold) tick();
        keypad = '0;
        repeat (rel) tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [9:0]  kp;
        logic        en;
        logic        clr;
        logic        valid;
        logic [3:0]  bcd;
        logic        multi;
        logic [15:0] dig;
    } vec_t;

    vec_t vecs[21];

    task automatic set_vec(input int i, input logic [9:0] kp, input logic clr, input logic v,
                           input logic [3:0] bcd, input logic m, input logic [15:0] dig);
        vecs[i].kp = kp; vecs[i].en = 1'b1; vecs[i].clr = clr; vecs[i].valid = v;
        vecs[i].bcd = bcd; vecs[i].multi = m; vecs[i].dig = dig;
    endtask

    initial begin
        int got;
        logic [9:0] r;
        model_reset();

        // press 1, release, press 2 with a same-cycle clear, then a multi-key press
        set_vec(0,  10'h002, 0, 0, 1, 0, 16'h0000);
        set_vec(1,  10'h002, 0, 0, 1, 0, 16'h0000);
        set_vec(2,  10'h002, 0, 1, 1, 0, 16'h0000);
        set_vec(3,  10'h002, 0, 0, 1, 0, 16'h0001);
        set_vec(4,  10'h000, 0, 0, 1, 0, 16'h0001);
        set_vec(5,  10'h000, 0, 0, 1, 0, 16'h0001);
        set_vec(6,  10'h000, 0, 0, 1, 0, 16'h0001);
        set_vec(7,  10'h004, 0, 0, 1, 0, 16'h0001);
        set_vec(8,  10'h004, 0, 0, 1, 0, 16'h0001);
        set_vec(9,  10'h004, 0, 1, 2, 0, 16'h0001);
        set_vec(10, 10'h004, 1, 0, 2, 0, 16'h0000);
        set_vec(11, 10'h006, 0, 0, 2, 0, 16'h0000);
        set_vec(12, 10'h006, 0, 0, 2, 0, 16'h0000);
        set_vec(13, 10'h000, 0, 0, 2, 0, 16'h0000);
        set_vec(14, 10'h000, 0, 0, 2, 0, 16'h0000);
        set_vec(15, 10'h000, 0, 0, 2, 0, 16'h0000);
        set_vec(16, 10'h006, 0, 0, 2, 0, 16'h0000);
        set_vec(17, 10'h006, 0, 0, 2, 1, 16'h0000);
        set_vec(18, 10'h000, 0, 0, 2, 1, 16'h0000);
        set_vec(19, 10'h000, 0, 0, 2, 1, 16'h0000);
        set_vec(20, 10'h000, 0, 0, 2, 0, 16'h0000);

        // 1: reset with key 1 held, entry disabled
        keypad = 10'h002;
        #2 clearn = 1'b0;
        #2;
        check("rst_key_valid", key_valid, 0);
        check("rst_key_bcd", key_bcd, 0);
        check("rst_multi", multi_key, 0);
        check("rst_digits", dut_digits(), 0);
        @(negedge clk);
        clearn = 1'b1;
        model_reset();
        pulse_cnt = 0;
        repeat (8) tick();
        check("rst_pulses", pulse_cnt, 1);
        check("rst_bcd_after", key_bcd, 1);
        keypad = '0;
        repeat (4) tick();

        // 2: table
        foreach (vecs[i]) begin
            keypad = vecs[i].kp;
            entry_en = vecs[i].en;
            digit_clr = vecs[i].clr;
            tick();
            check($sformatf("vec%0d_valid", i), key_valid, vecs[i].valid);
            check($sformatf("vec%0d_bcd", i), key_bcd, vecs[i].bcd);
            check($sformatf("vec%0d_multi", i), multi_key, vecs[i].multi);
            check($sformatf("vec%0d_digits", i), dut_digits(), vecs[i].dig);
        end
        digit_clr = 1'b0;
        keypad = '0;
        repeat (3) tick();

        // 3: overflow keeps the newest four digits
        pulse_cnt = 0;
        for (int k = 1; k <= 5; k++) press(k, 10, 10, 1);
        check("ovf_pulses", pulse_cnt, 5);
        check("ovf_digits", dut_digits(), 16'h2345);
        digit_clr = 1'b1;
        tick();
        digit_clr = 1'b0;
        check("clr_digits", dut_digits(), 16'h0000);

        // 4: bounce on key 7 never qualifies
        pulse_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            keypad = (c % 2 == 0) ? 10'h080 : 10'h000;
            tick();
        end
        keypad = '0;
        repeat (4) tick();
        check("bounce_pulses", pulse_cnt, 0);
        check("bounce_digits", dut_digits(), 16'h0000);

        // 5: multi-key flagged from the cycle after E1
        pulse_cnt = 0;
        keypad = 10'h006;
        tick();
        check("multi_e0", multi_key, 0);
        tick();
        check("multi_e1", multi_key, 1);
        repeat (3) tick();
        keypad = '0;
        repeat (4) tick();
        check("multi_pulses", pulse_cnt, 0);
        check("multi_released", multi_key, 0);

        // 6: gating and clear colliding with a press
        press(3, 6, 6, 1);
        pulse_cnt = 0;
        press(9, 6, 6, 0);
        check("gate_pulses", pulse_cnt, 1);
        check("gate_bcd", key_bcd, 9);
        check("gate_digits", dut_digits(), 16'h0003);
        entry_en = 1'b1;
        keypad = 10'h100;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (key_valid) got = 1;
        end
        check("clrpress_seen", got, 1);
        digit_clr = 1'b1;
        tick();
        digit_clr = 1'b0;
        check("clrpress_digits", dut_digits(), 16'h0000);
        keypad = '0;
        repeat (4) tick();

        // randomized traffic against the model
        for (int it = 0; it < 250; it++) begin
            entry_en = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin
                    keypad = 10'(1) << $urandom_range(0, 9);
                    repeat ($urandom_range(1, 6)) begin
                        digit_clr = ($urandom_range(0, 19) == 0);
                        tick();
                    end
                end
                1: begin
                    r = 10'(1) << $urandom_range(0, 9);
                    repeat ($urandom_range(1, 6)) begin
                        keypad = $urandom_range(0, 1) ? r : 10'h000;
                        tick();
                    end
                end
                2: begin
                    keypad = 10'($urandom_range(0, 1023));
                    repeat ($urandom_range(1, 5)) tick();
                end
                default: begin
                    repeat ($urandom_range(1, 4)) begin
                        keypad = 10'($urandom_range(0, 1023)) & 10'($urandom_range(0, 1023));
                        tick();
                    end
                end
            endcase
            digit_clr = 1'b0;
            keypad = '0;
            repeat ($urandom_range(0, 4)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
